dice_roller: RTL and testbench
==============================

DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the roll_btn synchronizer (minimum 2).
REQ-002 Parameter SLOW_STEPS, default 8: number of face advances in the deceleration phase (1..15).
REQ-003 Parameter STEP_BASE, default 4: cycles per face advance in the first deceleration step (1..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 roll_btn  input  1  asynchronous roll push-button level, high = pressed.
REQ-007 value  output  3  binary die face, 1..6, bit 2 = MSB; feeds the dice display decoder (A=value[2], B=value[1], C=value[0]).
REQ-008 rolling  output  1  high while the die is spinning or decelerating.
REQ-009 done  output  1  one-cycle pulse when a roll settles.
REQ-010 face_valid  output  1  high while value holds a settled roll result.

Function
REQ-011 roll_btn SHALL pass through a SYNC_STAGES-deep flop chain; only the synchronized level roll_s is used internally.
REQ-012 The FSM SHALL have exactly three states: IDLE, SPIN, SLOW.
REQ-013 IDLE: value held; roll_s=1 -> SPIN.
REQ-014 SPIN: value advances by one face every cycle; roll_s=0 -> SLOW. The advance in the exit cycle still occurs.
REQ-015 Face advance SHALL be 1->2->3->4->5->6->1; value SHALL never be 0 or 7.
REQ-016 On SLOW entry, step index k=0 and interval counter = STEP_BASE.
REQ-017 In SLOW, the interval counter decrements each cycle. On expiry: value advances one face, k increments, counter reloads STEP_BASE*(k+1).
REQ-018 When the SLOW_STEPS-th advance occurs, the FSM SHALL go to IDLE, pulse done for exactly that transition cycle + 1 (done high the first IDLE cycle), and set face_valid=1.
REQ-019 Total SLOW duration SHALL equal STEP_BASE*SLOW_STEPS*(SLOW_STEPS+1)/2 cycles (144 with defaults). Final face = first-SLOW-cycle face + SLOW_STEPS, mod-6 within 1..6.
REQ-020 roll_s=1 during SLOW SHALL return to SPIN next cycle (re-roll); k and the interval counter are discarded, with no done pulse.
REQ-021 face_valid SHALL clear in the first SPIN cycle and remain 0 through SPIN and SLOW.
REQ-022 rolling SHALL be a registered Moore output: 1 in SPIN and SLOW, 0 in IDLE.
REQ-023 Latency: roll_btn rise to rolling=1 SHALL be SYNC_STAGES+1 cycles.
REQ-024 The interval counter width SHALL be sized to hold STEP_BASE*SLOW_STEPS without overflow.

Reset
REQ-025 rst_n=0 SHALL immediately clear all of the following: state=IDLE, value=1, rolling=0, done=0, face_valid=0, k=0, interval counter=0, synchronizer=0.
REQ-026 Reset asserted mid-SPIN or mid-SLOW SHALL abort the roll with no done pulse.
REQ-027 After rst_n deassertion, no roll SHALL start until roll_s is high.

Structure
REQ-028 Shared package dice_pkg SHALL hold the state enum (IDLE, SPIN, SLOW) and the constants FACE_MIN=1 and FACE_MAX=6.
REQ-029 The synchronizer SHALL be a sub-module dice_sync (parameter SYNC_STAGES; ports clk, rst_n, d, q).

Verification
REQ-030 Reset release, roll_btn=0 for 50 cycles -> value=1, rolling=0, face_valid=0, done never high.
REQ-031 Hold roll_btn for 20 cycles -> rolling rises SYNC_STAGES+1 cycles after the press; value steps 1..6 cyclically each SPIN cycle.
REQ-032 Release roll_btn timed so the first-SLOW-cycle face=5 -> value=1 after 144 SLOW cycles; done pulses once; face_valid=1; rolling=0.
REQ-033 Re-press roll_btn 30 cycles into SLOW -> return to SPIN; face_valid stays 0; no done pulse; the later release completes normally.
REQ-034 Assert rst_n=0 mid-SLOW -> all outputs at reset values in the same cycle; no done pulse after release.
REQ-035 Random presses and releases over 10k cycles -> value always in 1..6; done count = completed rolls; done always coincides with a face_valid rise.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: FSM state encoding and die face limits shared by the dice roller
// and its test environment.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    SLOW = 2'd2
  } state_e;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  // Any out-of-range code folds back to FACE_MIN, so 0 and 7 can never persist.
  function automatic logic [2:0] next_face(input logic [2:0] face);
    return (face >= FACE_MAX || face < FACE_MIN) ? FACE_MIN : face + 3'd1;
  endfunction

endpackage

// File: rtl/dice_sync.sv
// dice_sync: multi-flop level synchronizer for the asynchronous roll button.
module dice_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dice_roller.sv
// dice_roller: push-button electronic die. Spins one face per cycle while the
// button is held, then decelerates through SLOW_STEPS progressively longer steps.
module dice_roller
  import dice_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SLOW_STEPS  = 8,
  parameter int STEP_BASE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_btn,
  output logic [2:0] value,
  output logic       rolling,
  output logic       done,
  output logic       face_valid
);

  // state | meaning
  // IDLE  | face held, waiting for the synchronized button
  // SPIN  | button held, face advances every cycle
  // SLOW  | decelerating, step k lasts STEP_BASE*(k+1) cycles

  localparam int CNT_MAX = STEP_BASE * SLOW_STEPS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int KW      = $clog2(SLOW_STEPS + 1);

  logic          roll_s;
  state_e        state_q, state_d;
  logic [2:0]    value_q, value_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rolling_q, rolling_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          step_tc;
  logic          last_step;
  logic [CW-1:0] reload;

  dice_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (roll_btn),
    .q    (roll_s)
  );

  assign step_tc   = (cnt_q == CW'(1));
  assign last_step = (k_q == KW'(SLOW_STEPS - 1));
  // Length of the step that follows the one expiring now (index k+1).
  assign reload    = CW'(STEP_BASE * (int'(k_q) + 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      value_q   <= FACE_MIN;
      k_q       <= '0;
      cnt_q     <= '0;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        k_d   = '0;
        cnt_d = '0;
        if (roll_s) begin
          state_d = SPIN;
          valid_d = 1'b0;
        end
      end

      SPIN: begin
        value_d = next_face(value_q);
        if (!roll_s) begin
          state_d = SLOW;
          k_d     = '0;
          cnt_d   = CW'(STEP_BASE);
        end
      end

      SLOW: begin
        // A new press pre-empts any step expiring in the same cycle.
        if (roll_s) begin
          state_d = SPIN;
          k_d     = '0;
          cnt_d   = '0;
        end else if (step_tc) begin
          value_d = next_face(value_q);
          if (last_step) begin
            state_d = IDLE;
            k_d     = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            k_d   = k_q + KW'(1);
            cnt_d = reload;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        k_d     = '0;
        cnt_d   = '0;
      end
    endcase

    rolling_d = (state_d != IDLE);
  end

  assign value      = value_q;
  assign rolling    = rolling_q;
  assign done       = done_q;
  assign face_valid = valid_q;

endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: scenario tasks for the dice roller with an elapsed-time
// reference model feeding a settled-face scoreboard.
module tb_dice_roller;

  localparam int SYNC_STAGES = 2;
  localparam int SLOW_STEPS  = 8;
  localparam int STEP_BASE   = 4;
  localparam int SLOW_CYCLES = STEP_BASE * SLOW_STEPS * (SLOW_STEPS + 1) / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       roll_btn = 1'b0;
  logic [2:0] value;
  logic       rolling;
  logic       done;
  logic       face_valid;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int exp_q[$];
  bit model_sb_en = 1'b0;
  int first_slow_exp = 0;

  dice_roller #(
    .SYNC_STAGES(SYNC_STAGES),
    .SLOW_STEPS (SLOW_STEPS),
    .STEP_BASE  (STEP_BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .roll_btn  (roll_btn),
    .value     (value),
    .rolling   (rolling),
    .done      (done),
    .face_valid(face_valid)
  );

  always #5 clk = ~clk;

  // Reference model: deceleration tracked as elapsed SLOW cycles, with the
  // j-th advance due when the elapsed count reaches STEP_BASE*j*(j+1)/2.
  logic [SYNC_STAGES-1:0] m_sync;
  int m_state, m_val, m_el, m_adv, m_tri;
  int m_done_cnt = 0;
  bit m_rs, m_roll, m_done, m_fv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = '0; m_state = 0; m_val = 1; m_el = 0; m_adv = 0;
      m_roll = 1'b0; m_done = 1'b0; m_fv = 1'b0;
    end else begin
      m_rs   = m_sync[SYNC_STAGES-1];
      m_sync = {m_sync[SYNC_STAGES-2:0], roll_btn};
      m_done = 1'b0;
      case (m_state)
        0: if (m_rs) begin m_state = 1; m_fv = 1'b0; end
        1: begin
          m_val = (m_val % 6) + 1;
          if (!m_rs) begin m_state = 2; m_el = 0; m_adv = 0; end
        end
        default: begin
          if (m_rs) begin
            m_state = 1;
          end else begin
            m_el++;
            m_tri = STEP_BASE * (m_adv + 1) * (m_adv + 2) / 2;
            if (m_el == m_tri) begin
              m_val = (m_val % 6) + 1;
              m_adv++;
              if (m_adv == SLOW_STEPS) begin
                m_state = 0; m_done = 1'b1; m_fv = 1'b1; m_done_cnt++;
                if (model_sb_en) exp_q.push_back(m_val);
              end
            end
          end
        end
      endcase
      m_roll = (m_state != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; roll_btn = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if (value !== 3'd1 || rolling !== 1'b0 || done !== 1'b0 || face_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_state: value=%0d rolling=%b done=%b face_valid=%b, expected 1/0/0/0",
               value, rolling, done, face_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      vec_cnt++;
      if (value !== 3'd1 || rolling !== 1'b0 || done !== 1'b0 || face_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL idle_hold cycle %0d: value=%0d rolling=%b done=%b face_valid=%b, expected 1/0/0/0",
                 i, value, rolling, done, face_valid);
      end
    end
  endtask

  task automatic test_spin();
    int n, v0, exp_v;
    v0 = int'(value);
    roll_btn = 1'b1;
    n = 0;
    while (rolling !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    vec_cnt++;
    if (rolling !== 1'b1 || n != SYNC_STAGES + 1) begin
      miss_cnt++;
      $display("FAIL press_latency: rolling=%b after %0d cycles, expected 1 after %0d",
               rolling, n, SYNC_STAGES + 1);
    end
    vec_cnt++;
    if (face_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL spin_face_valid: face_valid=%b, expected 0", face_valid);
    end
    exp_v = v0;
    while (n < 20 || ((v0 - 1 + n) % 6) != 4) begin
      vec_cnt++;
      if (value !== 3'(exp_v) || rolling !== 1'b1) begin
        miss_cnt++;
        $display("FAIL spin_step n=%0d: value=%0d rolling=%b, expected %0d/1", n, value, rolling, exp_v);
      end
      tick(); n++;
      exp_v = (exp_v % 6) + 1;
    end
    vec_cnt++;
    if (value !== 3'(exp_v) || rolling !== 1'b1) begin
      miss_cnt++;
      $display("FAIL spin_step n=%0d: value=%0d rolling=%b, expected %0d/1", n, value, rolling, exp_v);
    end
    roll_btn = 1'b0;
    first_slow_exp = ((v0 - 1 + n) % 6) + 1;
    exp_q.push_back(((v0 - 1 + n + SLOW_STEPS) % 6) + 1);
  endtask

  task automatic test_slow_complete();
    int c, dones, done_at, exp_f;
    c = 0; dones = 0; done_at = -1;
    while (c < SLOW_CYCLES + 60) begin
      tick(); c++;
      if (c == SYNC_STAGES + 1) begin
        vec_cnt++;
        if (value !== 3'(first_slow_exp)) begin
          miss_cnt++;
          $display("FAIL slow_entry_face: value=%0d, expected %0d", value, first_slow_exp);
        end
      end
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) begin
          done_at = c;
          vec_cnt++;
          exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          if (value !== 3'(exp_f) || exp_f < 0) begin
            miss_cnt++;
            $display("FAIL settle_face: value=%0d, expected %0d", value, exp_f);
          end
          vec_cnt++;
          if (face_valid !== 1'b1 || rolling !== 1'b0) begin
            miss_cnt++;
            $display("FAIL settle_flags: face_valid=%b rolling=%b, expected 1/0", face_valid, rolling);
          end
        end
      end else if (done_at < 0 && (face_valid !== 1'b0 || rolling !== 1'b1)) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL slow_busy c=%0d: face_valid=%b rolling=%b, expected 0/1", c, face_valid, rolling);
      end
      if (done_at >= 0 && c >= done_at + 10) break;
    end
    vec_cnt++;
    if (done_at != SYNC_STAGES + 1 + SLOW_CYCLES) begin
      miss_cnt++;
      $display("FAIL slow_duration: done at cycle %0d after release, expected %0d",
               done_at, SYNC_STAGES + 1 + SLOW_CYCLES);
    end
    vec_cnt++;
    if (dones != 1) begin
      miss_cnt++;
      $display("FAIL done_once: %0d done pulses, expected 1", dones);
    end
    vec_cnt++;
    if (face_valid !== 1'b1 || rolling !== 1'b0 || value !== 3'd1) begin
      miss_cnt++;
      $display("FAIL settled_hold: value=%0d face_valid=%b rolling=%b, expected 1/1/0",
               value, face_valid, rolling);
    end
  endtask

  task automatic test_reroll();
    int n, dones, bad, exp_f;
    model_sb_en = 1'b1;
    roll_btn = 1'b1;
    n = 0;
    while (rolling !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    vec_cnt++;
    if (rolling !== 1'b1 || face_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL fv_clear_on_spin: rolling=%b face_valid=%b, expected 1/0", rolling, face_valid);
    end
    repeat (7) tick();
    roll_btn = 1'b0;
    dones = 0; bad = 0;
    repeat (SYNC_STAGES + 1 + 30) begin
      tick();
      if (done === 1'b1) dones++;
      if (face_valid !== 1'b0 || rolling !== 1'b1) bad++;
    end
    roll_btn = 1'b1;
    repeat (10) begin
      tick();
      if (done === 1'b1) dones++;
      if (face_valid !== 1'b0 || rolling !== 1'b1) bad++;
    end
    vec_cnt++;
    if (dones != 0 || bad != 0) begin
      miss_cnt++;
      $display("FAIL reroll_window: %0d done pulses and %0d flag errors, expected 0 and 0", dones, bad);
    end
    roll_btn = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < SLOW_CYCLES + 60) begin
      tick(); n++;
    end
    vec_cnt++;
    exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (done !== 1'b1 || value !== 3'(exp_f) || face_valid !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reroll_settle: done=%b value=%0d face_valid=%b, expected 1/%0d/1",
               done, value, face_valid, exp_f);
    end
    tick();
    vec_cnt++;
    if (done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL done_width: done=%b one cycle later, expected 0", done);
    end
    model_sb_en = 1'b0;
  endtask

  task automatic test_reset_mid_slow();
    int dones, bad;
    roll_btn = 1'b1;
    repeat (12) tick();
    roll_btn = 1'b0;
    repeat (SYNC_STAGES + 1 + 40) tick();
    vec_cnt++;
    if (rolling !== 1'b1) begin
      miss_cnt++;
      $display("FAIL mid_slow_active: rolling=%b, expected 1", rolling);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (value !== 3'd1 || rolling !== 1'b0 || done !== 1'b0 || face_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset_async: value=%0d rolling=%b done=%b face_valid=%b, expected 1/0/0/0",
               value, rolling, done, face_valid);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    dones = 0; bad = 0;
    repeat (200) begin
      tick();
      if (done === 1'b1) dones++;
      if (value !== 3'd1 || rolling !== 1'b0 || face_valid !== 1'b0) bad++;
    end
    vec_cnt++;
    if (dones != 0 || bad != 0) begin
      miss_cnt++;
      $display("FAIL post_reset_idle: %0d done pulses and %0d state errors, expected 0 and 0", dones, bad);
    end
  endtask

  task automatic test_random();
    int rem, base, dut_dones, exp_f;
    bit prev_fv;
    model_sb_en = 1'b1;
    exp_q.delete();
    base = m_done_cnt;
    dut_dones = 0;
    prev_fv = face_valid;
    rem = 0;
    for (int i = 0; i < 10000; i++) begin
      if (rem == 0) begin
        roll_btn = ~roll_btn;
        rem = roll_btn ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 260));
      end
      rem--;
      tick();
      vec_cnt++;
      if ($isunknown(value) || value < 3'd1 || value > 3'd6) begin
        miss_cnt++;
        $display("FAIL face_range cycle %0d: value=%0d, expected 1..6", i, value);
      end
      vec_cnt++;
      if (value !== 3'(m_val) || rolling !== m_roll || done !== m_done || face_valid !== m_fv) begin
        miss_cnt++;
        $display("FAIL model_track cycle %0d: value/rolling/done/fv=%0d/%b/%b/%b, expected %0d/%b/%b/%b",
                 i, value, rolling, done, face_valid, m_val, m_roll, m_done, m_fv);
      end
      if (done === 1'b1) begin
        dut_dones++;
        vec_cnt++;
        if (face_valid !== 1'b1 || prev_fv !== 1'b0) begin
          miss_cnt++;
          $display("FAIL done_fv_rise cycle %0d: face_valid %b->%b, expected 0->1", i, prev_fv, face_valid);
        end
        vec_cnt++;
        exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (value !== 3'(exp_f)) begin
          miss_cnt++;
          $display("FAIL random_settle cycle %0d: value=%0d, expected %0d", i, value, exp_f);
        end
      end
      prev_fv = face_valid;
    end
    roll_btn = 1'b0;
    vec_cnt++;
    if (dut_dones != m_done_cnt - base || exp_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL done_count: %0d done pulses with %0d unmatched, expected %0d and 0",
               dut_dones, exp_q.size(), m_done_cnt - base);
    end
    model_sb_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_spin();
    test_slow_complete();
    test_reroll();
    test_reset_mid_slow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
